// File: rtl/ide_pio_target.sv
// ATA PIO device-side target: task-file registers, status/INTRQ handling and
// PIO data phases for READ SECTOR(S), WRITE SECTOR(S) and IDENTIFY.
module ide_pio_target #(
  parameter int BSY_MIN = 8,
  parameter int DEV_ID  = 0
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic [1:0]  CS_n,
  input  logic [2:0]  DA,
  input  logic        IOR_n,
  input  logic        IOW_n,
  input  logic [15:0] DD_IN,
  output logic [15:0] DD_OUT,
  output logic        DD_OE,
  output logic        INTRQ,
  output logic [7:0]  buf_addr,
  output logic [15:0] buf_wdata,
  output logic        buf_we,
  input  logic [15:0] buf_rdata,
  output logic        xfer_req,
  output logic        xfer_wr,
  output logic        xfer_id,
  output logic [27:0] xfer_lba,
  input  logic        xfer_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAITW, S_FILL, S_PREF, S_DRQ_RD, S_DRQ_WR, S_COMMIT
  } state_t;

  localparam logic [7:0] L_BSY = 8'(BSY_MIN);
  localparam logic       L_DEV = DEV_ID[0];

  state_t      r_state, w_nxt;
  logic [2:0]  r_ior_sync, r_iow_sync;
  logic [1:0]  r_devctl;
  logic [7:0]  r_err, r_cnt, r_dev, r_baddr, r_bcnt;
  logic [23:0] r_lba;
  logic        r_bsy, r_drq, r_errb, r_intrq, r_xreq, r_xwr, r_xid, r_acked, r_rd_da0;
  logic        r_fetch_p0, r_fetch_p1, r_we_p0;
  logic [15:0] r_rdword, r_wdata;

  logic        w_iow_fall, w_ior_fall, w_ior_rise, w_cmd_sel, w_ctl_sel, w_dev_ok;
  logic        w_srst, w_rst, w_bsy, w_drdy, w_tf_wr, w_cmd_go, w_data_wr, w_rd_end;
  logic        w_bsy_done, w_stat_rd;
  logic [7:0]  w_status;
  logic [27:0] w_lba, w_lba_inc;
  logic        w_go_fill, w_go_wrwait, w_abort, w_pref, w_fetch, w_rd_ready, w_rd_inc;
  logic        w_rd_last, w_rd_next, w_go_drqwr, w_wr_inc, w_go_commit;
  logic        w_commit_last, w_commit_next;

  // [0] metastability flop, [1] synchronised level, [2] previous level
  assign w_iow_fall = r_iow_sync[2] & ~r_iow_sync[1];
  assign w_ior_fall = r_ior_sync[2] & ~r_ior_sync[1] & ~w_iow_fall;
  assign w_ior_rise = ~r_ior_sync[2] & r_ior_sync[1] & ~w_iow_fall;

  assign w_cmd_sel  = (CS_n == 2'b10);
  assign w_ctl_sel  = (CS_n == 2'b01) && (DA == 3'd6);
  assign w_dev_ok   = (r_dev[4] == L_DEV);
  assign w_srst     = r_devctl[1];
  assign w_rst      = ~RESET_n | w_srst;
  assign w_bsy      = r_bsy | w_srst;
  assign w_drdy     = ~w_srst;
  assign w_status   = {w_bsy, w_drdy, 1'b0, w_drdy, r_drq, 2'b00, r_errb};
  assign w_lba      = {r_dev[3:0], r_lba};
  assign w_lba_inc  = w_lba + 28'd1;
  assign w_bsy_done = (r_bcnt >= L_BSY);

  assign w_tf_wr    = w_iow_fall & w_cmd_sel & ~w_bsy & ~r_drq;
  assign w_cmd_go   = w_tf_wr & (DA == 3'd7) & w_dev_ok & (r_state == S_IDLE);
  assign w_data_wr  = w_iow_fall & w_cmd_sel & (DA == 3'd0) & (r_state == S_DRQ_WR) & r_drq;
  assign w_rd_end   = w_ior_rise & r_rd_da0 & (r_state == S_DRQ_RD);
  assign w_stat_rd  = w_ior_fall & w_cmd_sel & (DA == 3'd7) & w_dev_ok;

  assign DD_OE      = ~r_ior_sync[1] & (w_cmd_sel | w_ctl_sel) & w_dev_ok;
  assign INTRQ      = r_intrq & ~r_devctl[0];
  assign buf_addr   = r_baddr;
  assign buf_wdata  = r_wdata;
  assign buf_we     = r_we_p0;
  assign xfer_req   = r_xreq;
  assign xfer_wr    = r_xwr;
  assign xfer_id    = r_xid;
  assign xfer_lba   = w_lba;

  always_comb begin
    DD_OUT = '0;
    if (w_ctl_sel) DD_OUT = {8'h00, w_status};
    else if (w_cmd_sel) begin
      case (DA)
        3'd0:    DD_OUT = (r_state == S_DRQ_RD) ? r_rdword : 16'h0000;
        3'd1:    DD_OUT = {8'h00, r_err};
        3'd2:    DD_OUT = {8'h00, r_cnt};
        3'd3:    DD_OUT = {8'h00, r_lba[7:0]};
        3'd4:    DD_OUT = {8'h00, r_lba[15:8]};
        3'd5:    DD_OUT = {8'h00, r_lba[23:16]};
        3'd6:    DD_OUT = {8'h00, r_dev};
        default: DD_OUT = {8'h00, w_status};
      endcase
    end
  end

  always_comb begin
    w_nxt = r_state;
    w_go_fill = 1'b0; w_go_wrwait = 1'b0; w_abort = 1'b0; w_pref = 1'b0;
    w_fetch = 1'b0; w_rd_ready = 1'b0; w_rd_inc = 1'b0; w_rd_last = 1'b0;
    w_rd_next = 1'b0; w_go_drqwr = 1'b0; w_wr_inc = 1'b0; w_go_commit = 1'b0;
    w_commit_last = 1'b0; w_commit_next = 1'b0;
    case (r_state)
      S_IDLE: if (w_cmd_go) begin
        if (DD_IN[7:0] == 8'h20 || DD_IN[7:0] == 8'hEC) begin
          w_nxt = S_FILL; w_go_fill = 1'b1;
        end else if (DD_IN[7:0] == 8'h30) begin
          w_nxt = S_WAITW; w_go_wrwait = 1'b1;
        end else w_abort = 1'b1;
      end
      S_WAITW: if (w_bsy_done) begin w_nxt = S_DRQ_WR; w_go_drqwr = 1'b1; end
      S_FILL: if (r_acked && w_bsy_done) begin
        w_nxt = S_PREF; w_pref = 1'b1; w_fetch = 1'b1;
      end
      S_PREF: if (r_fetch_p1) begin w_nxt = S_DRQ_RD; w_rd_ready = 1'b1; end
      S_DRQ_RD: if (w_rd_end) begin
        if (r_baddr != 8'hFF) begin
          w_rd_inc = 1'b1; w_fetch = 1'b1;
        end else if (r_xid || r_cnt == 8'd1) begin
          w_nxt = S_IDLE; w_rd_last = 1'b1;
        end else begin
          w_nxt = S_FILL; w_rd_next = 1'b1;
        end
      end
      S_DRQ_WR: if (r_we_p0) begin
        if (r_baddr == 8'hFF) begin w_nxt = S_COMMIT; w_go_commit = 1'b1; end
        else w_wr_inc = 1'b1;
      end
      S_COMMIT: if (xfer_ack) begin
        if (r_cnt == 8'd1) begin w_nxt = S_IDLE; w_commit_last = 1'b1; end
        else begin w_nxt = S_DRQ_WR; w_commit_next = 1'b1; end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      r_ior_sync <= 3'b111;
      r_iow_sync <= 3'b111;
      r_devctl   <= 2'b00;
    end else begin
      r_ior_sync <= {r_ior_sync[1:0], IOR_n};
      r_iow_sync <= {r_iow_sync[1:0], IOW_n};
      if (w_iow_fall && w_ctl_sel) r_devctl <= DD_IN[2:1];
    end
  end

  // SRST holds the whole task file and transfer engine in reset
  always_ff @(posedge CLK) begin
    if (w_rst) begin
      r_state <= S_IDLE; r_err <= 8'h01; r_cnt <= 8'h01; r_lba <= 24'h1;
      r_dev <= 8'h00; r_bsy <= 1'b0; r_drq <= 1'b0; r_errb <= 1'b0;
      r_intrq <= 1'b0; r_xreq <= 1'b0; r_xwr <= 1'b0; r_xid <= 1'b0;
      r_baddr <= 8'h00; r_bcnt <= 8'h00; r_acked <= 1'b0; r_rd_da0 <= 1'b0;
      r_fetch_p0 <= 1'b0; r_fetch_p1 <= 1'b0; r_we_p0 <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_fetch_p0 <= w_fetch;
      r_fetch_p1 <= r_fetch_p0;
      r_we_p0    <= w_data_wr;
      if (r_bcnt != 8'hFF) r_bcnt <= r_bcnt + 8'd1;
      if (w_ior_fall) r_rd_da0 <= w_cmd_sel & (DA == 3'd0) & w_dev_ok;
      if (w_stat_rd) r_intrq <= 1'b0;
      if (w_tf_wr) begin
        case (DA)
          3'd2:    r_cnt <= DD_IN[7:0];
          3'd3:    r_lba[7:0] <= DD_IN[7:0];
          3'd4:    r_lba[15:8] <= DD_IN[7:0];
          3'd5:    r_lba[23:16] <= DD_IN[7:0];
          3'd6:    r_dev <= DD_IN[7:0];
          default: ;
        endcase
      end
      if (r_state == S_FILL && xfer_ack) begin r_acked <= 1'b1; r_xreq <= 1'b0; end
      if (w_go_fill) begin
        r_bsy <= 1'b1; r_errb <= 1'b0; r_xreq <= 1'b1; r_xwr <= 1'b0;
        r_xid <= (DD_IN[7:0] == 8'hEC); r_bcnt <= 8'h00; r_acked <= 1'b0;
      end
      if (w_go_wrwait) begin r_bsy <= 1'b1; r_errb <= 1'b0; r_bcnt <= 8'h00; end
      if (w_abort) begin r_err <= 8'h04; r_errb <= 1'b1; r_intrq <= 1'b1; end
      if (w_pref) r_baddr <= 8'h00;
      if (w_rd_ready) begin r_bsy <= 1'b0; r_drq <= 1'b1; r_intrq <= 1'b1; end
      if (w_rd_inc || w_wr_inc) r_baddr <= r_baddr + 8'd1;
      if (w_rd_last) begin r_drq <= 1'b0; r_baddr <= 8'h00; end
      if (w_rd_next) begin
        r_drq <= 1'b0; r_baddr <= 8'h00; r_bsy <= 1'b1; r_xreq <= 1'b1;
        r_xwr <= 1'b0; r_bcnt <= 8'h00; r_acked <= 1'b0;
        {r_dev[3:0], r_lba} <= w_lba_inc; r_cnt <= r_cnt - 8'd1;
      end
      if (w_go_drqwr) begin r_bsy <= 1'b0; r_drq <= 1'b1; r_baddr <= 8'h00; end
      if (w_go_commit) begin
        r_baddr <= 8'h00; r_drq <= 1'b0; r_bsy <= 1'b1; r_xreq <= 1'b1; r_xwr <= 1'b1;
      end
      if (w_commit_last) begin r_xreq <= 1'b0; r_intrq <= 1'b1; r_bsy <= 1'b0; end
      if (w_commit_next) begin
        r_xreq <= 1'b0; r_intrq <= 1'b1; r_drq <= 1'b1; r_bsy <= 1'b0; r_baddr <= 8'h00;
        {r_dev[3:0], r_lba} <= w_lba_inc; r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (r_fetch_p1) r_rdword <= buf_rdata;
    if (w_data_wr) r_wdata <= DD_IN;
  end

endmodule
